// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw button lines / consumer logic and the conditioner.
// The master drives the raw lines and repeat enable; the slave returns conditioned events.
interface button_conditioner_if #(
  parameter int NUM_CH = 12,
  parameter int CODE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] i_raw;
  logic              i_repeat_en;
  logic [NUM_CH-1:0] o_level;
  logic [NUM_CH-1:0] o_press;
  logic [NUM_CH-1:0] o_release;
  logic              o_valid;
  logic [CODE_W-1:0] o_code;
  logic              o_multi;

  modport master (
    output i_raw, i_repeat_en,
    input  o_level, o_press, o_release, o_valid, o_code, o_multi
  );

  modport slave (
    input  i_raw, i_repeat_en,
    output o_level, o_press, o_release, o_valid, o_code, o_multi
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchroniser, counter debounce, press/release pulses and auto-repeat,
// plus a lowest-index priority encoder over the press pulses.
module button_conditioner #(
  parameter int NUM_CH        = 12,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int CODE_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic                clk,
  input logic                rst_n,
  button_conditioner_if.slave bus
);

  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  logic [NUM_CH-1:0] pol;
  logic [NUM_CH-1:0] level_v;
  logic [NUM_CH-1:0] press_v;
  logic [NUM_CH-1:0] release_v;
  logic [CODE_W-1:0] code;

  assign pol = ACTIVE_LOW ? ~bus.i_raw : bus.i_raw;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [DB_W-1:0]        cnt;
    logic [RC_W-1:0]        rc;
    rep_state_t             state;
    logic                   level;
    logic                   press;
    logic                   rls;
    logic                   s;
    logic                   flip;
    logic                   level_next;

    assign s          = sync[SYNC_STAGES-1];
    assign flip       = (s != level) && (cnt == DB_W'(DB_CYCLES - 1));
    assign level_next = flip ? s : level;

    // The repeat FSM looks at the post-update level so a release wins over a
    // repeat pulse falling on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync  <= '0;
        cnt   <= '0;
        rc    <= '0;
        state <= IDLE;
        level <= 1'b0;
        press <= 1'b0;
        rls   <= 1'b0;
      end else begin
        sync  <= {sync[SYNC_STAGES-2:0], pol[ch]};
        press <= flip && s;
        rls   <= flip && !s;

        if (s == level) begin
          cnt <= '0;
        end else if (flip) begin
          level <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end

        if (!level_next || !bus.i_repeat_en) begin
          state <= IDLE;
          rc    <= '0;
        end else begin
          case (state)
            IDLE: begin
              state <= DELAY;
              rc    <= '0;
            end
            DELAY: begin
              if (rc == RC_W'(REPEAT_DELAY - 1)) begin
                press <= 1'b1;
                state <= REPEAT;
                rc    <= '0;
              end else begin
                rc <= rc + 1'b1;
              end
            end
            REPEAT: begin
              if (rc == RC_W'(REPEAT_PERIOD - 1)) begin
                press <= 1'b1;
                rc    <= '0;
              end else begin
                rc <= rc + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              rc    <= '0;
            end
          endcase
        end
      end
    end

    assign level_v[ch]   = level;
    assign press_v[ch]   = press;
    assign release_v[ch] = rls;
  end

  // Scan from the top so the lowest pressed index is the last one written.
  always_comb begin
    code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (press_v[i]) code = CODE_W'(i);
    end
  end

  assign bus.o_level   = level_v;
  assign bus.o_press   = press_v;
  assign bus.o_release = release_v;
  assign bus.o_valid   = |press_v;
  assign bus.o_code    = code;
  assign bus.o_multi   = |(press_v & (press_v - NUM_CH'(1)));

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulse events are queued when stimulus is driven and
// compared every cycle; cycles with no queued event must show no pulses.
module tb_button_conditioner;
  localparam int N = 12;

  typedef struct {
    int         cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] level;
    logic [3:0] code;
    logic       multi;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [3:0]   code;
    logic         multi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [N-1:0] cur_level = '0;
  exp_t sb[$];
  vec_t vecs[5];
  int p;
  int r;

  button_conditioner_if #(.NUM_CH(N)) bus();

  button_conditioner dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] model_code(input logic [N-1:0] pv);
    for (int i = 0; i < N; i++) if (pv[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic push_event(input int c, input logic [N-1:0] pv, input logic [N-1:0] rv,
                            input logic [N-1:0] lv);
    exp_t e;
    e.cyc = c;
    e.press = pv;
    e.rel = rv;
    e.level = lv;
    e.code = model_code(pv);
    e.multi = ($countones(pv) > 1);
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [N-1:0] raw, input logic en);
    @(posedge clk);
    #1;
    bus.i_raw = raw;
    bus.i_repeat_en = en;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] ep;
    logic [N-1:0] er;
    logic [3:0] ec;
    logic em;
    if (mon_en) begin
      ep = '0;
      er = '0;
      ec = '0;
      em = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ep = sb[0].press;
        er = sb[0].rel;
        ec = sb[0].code;
        em = sb[0].multi;
        cur_level = sb[0].level;
        void'(sb.pop_front());
      end
      check_output("press", 32'(bus.o_press), 32'(ep));
      check_output("release", 32'(bus.o_release), 32'(er));
      check_output("level", 32'(bus.o_level), 32'(cur_level));
      check_output("code", 32'(bus.o_code), 32'(ec));
      check_output("valid", 32'(bus.o_valid), 32'(|ep));
      check_output("multi", 32'(bus.o_multi), 32'(em));
    end
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_level"}, 32'(bus.o_level), 32'd0);
    check_output({tag, "_press"}, 32'(bus.o_press), 32'd0);
    check_output({tag, "_release"}, 32'(bus.o_release), 32'd0);
    check_output({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check_output({tag, "_code"}, 32'(bus.o_code), 32'd0);
    check_output({tag, "_multi"}, 32'(bus.o_multi), 32'd0);
  endtask

  initial begin
    vecs[0] = '{12'h008, 4'd3, 1'b0};
    vecs[1] = '{12'h204, 4'd2, 1'b1};
    vecs[2] = '{12'h001, 4'd0, 1'b0};
    vecs[3] = '{12'h800, 4'd11, 1'b0};
    vecs[4] = '{12'hFFF, 4'd0, 1'b1};

    bus.i_raw = '0;
    bus.i_repeat_en = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_until(cyc + 3);

    // Table: step a mask on, hold, release; repeat disabled.
    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].mask, 1'b0);
      begin
        exp_t e;
        e.cyc = cyc + 6;
        e.press = vecs[k].mask;
        e.rel = '0;
        e.level = vecs[k].mask;
        e.code = vecs[k].code;
        e.multi = vecs[k].multi;
        sb.push_back(e);
      end
      wait_until(cyc + 20);
      apply_stimulus('0, 1'b0);
      push_event(cyc + 6, '0, vecs[k].mask, '0);
      wait_until(cyc + 10);
    end

    // Bounce on ch0 then stable high.
    apply_stimulus(12'h001, 1'b0);
    apply_stimulus(12'h000, 1'b0);
    apply_stimulus(12'h001, 1'b0);
    apply_stimulus(12'h000, 1'b0);
    apply_stimulus(12'h001, 1'b0);
    push_event(cyc + 6, 12'h001, '0, 12'h001);
    wait_until(cyc + 15);
    apply_stimulus('0, 1'b0);
    push_event(cyc + 6, '0, 12'h001, '0);
    wait_until(cyc + 10);

    // 3-cycle pulse is filtered out.
    apply_stimulus(12'h001, 1'b0);
    wait_until(cyc + 2);
    apply_stimulus('0, 1'b0);
    wait_until(cyc + 12);

    // 4-cycle pulse is just long enough; release follows DB_CYCLES later.
    apply_stimulus(12'h001, 1'b0);
    r = cyc;
    wait_until(cyc + 3);
    apply_stimulus('0, 1'b0);
    push_event(r + 6, 12'h001, '0, 12'h001);
    push_event(r + 10, '0, 12'h001, '0);
    wait_until(cyc + 14);

    // Auto-repeat on ch1, full train.
    apply_stimulus('0, 1'b1);
    apply_stimulus(12'h002, 1'b1);
    p = cyc + 6;
    push_event(p, 12'h002, '0, 12'h002);
    for (int t = 8; t <= 28; t += 4) push_event(p + t, 12'h002, '0, 12'h002);
    wait_until(p + 28);
    apply_stimulus(12'h002, 1'b0);
    apply_stimulus('0, 1'b0);
    push_event(cyc + 6, '0, 12'h002, '0);
    wait_until(cyc + 10);

    // Repeat enable dropped mid-train, then raised again while held.
    apply_stimulus(12'h002, 1'b1);
    p = cyc + 6;
    push_event(p, 12'h002, '0, 12'h002);
    push_event(p + 8, 12'h002, '0, 12'h002);
    push_event(p + 12, 12'h002, '0, 12'h002);
    wait_until(p + 12);
    apply_stimulus(12'h002, 1'b0);
    wait_until(p + 19);
    apply_stimulus(12'h002, 1'b1);
    push_event(p + 29, 12'h002, '0, 12'h002);
    wait_until(p + 29);
    apply_stimulus(12'h002, 1'b0);
    apply_stimulus('0, 1'b0);
    push_event(cyc + 6, '0, 12'h002, '0);
    wait_until(cyc + 10);

    // Release lands on the edge where the first repeat would fire.
    apply_stimulus(12'h080, 1'b1);
    p = cyc + 6;
    push_event(p, 12'h080, '0, 12'h080);
    wait_until(p + 1);
    apply_stimulus('0, 1'b1);
    push_event(p + 8, '0, 12'h080, '0);
    wait_until(p + 14);
    apply_stimulus('0, 1'b0);
    wait_until(cyc + 4);

    // Reset during DELAY with the button still held.
    apply_stimulus(12'h010, 1'b1);
    p = cyc + 6;
    push_event(p, 12'h010, '0, 12'h010);
    wait_until(p + 3);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    cur_level = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    r = cyc;
    push_event(r + 6, 12'h010, '0, 12'h010);
    wait_until(r + 6);
    apply_stimulus(12'h010, 1'b0);
    apply_stimulus('0, 1'b0);
    push_event(cyc + 6, '0, 12'h010, '0);
    wait_until(cyc + 10);

    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
